if_prefetch_buffer: RTL and testbench

IF_PREFETCH_BUFFER -- requirements
Module: if_prefetch_buffer

---
 rtl/if_prefetch_buffer.sv | 179 +++++++++++++++++
 tb/tb_if_prefetch_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch prefetch buffer.
//
// Issues word fetches to instruction memory (one request outstanding at a
// time) and queues the returned words with their addresses in a circular
// buffer that feeds the IF/ID register. A redirect from MEM flushes the
// queue and restarts fetching at the new target. A fetch still in flight
// when the redirect arrives is allowed to finish, and its data is dropped.
// Halt stops new issues but lets the queue keep draining to decode.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   imem_req/addr     fetch request and word-aligned byte address (held while req high)
//   imem_ack/rdata    fetch accepted; rdata valid in the same cycle
//   redirect/_pc      flush and restart at {redirect_pc[31:2], 2'b00}
//   halt              level-sensitive; no new fetch while high
//   dec_valid/ready   head handshake toward IF/ID
//   dec_inst/pc       head entry (zero when the queue is empty)
//   dec_pc_add4       dec_pc + 4 (zero when the queue is empty)
//   occupancy         number of queued entries
module if_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_inst,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_pc_add4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_deq, count_after_enq;
  logic          enq, deq, flush;
  logic [31:0]   redirect_tgt, pc_plus4;

  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4     = fetch_pc_q + 32'd4;

  // Next-state and queue-control logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    enq        = 1'b0;
    flush      = 1'b0;
    // A redirect cancels any same-edge dequeue.
    deq             = dec_valid && dec_ready && !redirect;
    count_after_deq = count_q - CW'(deq);
    count_after_enq = count_after_deq + CW'(1);

    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
        end else if (!halt && (count_after_deq < FULL)) begin
          state_d = WAIT_ACK;
          addr_d  = fetch_pc_q;
        end
      end

      WAIT_ACK: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
          if (imem_ack) begin
            // Returned word is stale; go straight to the target.
            if (halt) begin
              state_d = IDLE;
            end else begin
              addr_d = redirect_tgt;
            end
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          enq        = 1'b1;
          fetch_pc_d = pc_plus4;
          if (!halt && (count_after_enq < FULL)) begin
            addr_d = pc_plus4;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          flush      = 1'b1;
        end
        // The ack retires the stale request; its data is never queued.
        // A redirect on the same edge simply replaces the restart target.
        if (imem_ack) begin
          if (halt) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_ACK;
            addr_d  = redirect ? redirect_tgt : fetch_pc_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    count_d = flush ? '0 : (count_after_deq + CW'(enq));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC_A;
      addr_q     <= RESET_PC_A;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Queue storage needs no reset: outputs are gated by dec_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = addr_q;
  assign occupancy   = count_q;
  assign dec_valid   = (count_q != '0);
  assign dec_inst    = dec_valid ? q_inst[rd_ptr_q] : '0;
  assign dec_pc      = dec_valid ? q_pc[rd_ptr_q] : '0;
  assign dec_pc_add4 = dec_valid ? (q_pc[rd_ptr_q] + 32'd4) : '0;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer (DEPTH = 4, RESET_PC = 0).
// A behavioural memory acks each request after a programmable latency and
// returns a word derived from the address. Expected fetch addresses and
// decode deliveries are queued by the directed sequence and consumed by a
// negedge monitor.
module tb_if_prefetch_buffer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_add4;
  logic [2:0]  occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_fetch [$];
  logic [31:0] exp_pc    [$];

  int unsigned mem_lat = 1;
  bit          mem_en  = 1'b1;
  int unsigned cnt     = 0;
  bit          req_prev = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  assign imem_rdata = inst_of(imem_addr);

  if_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_pc_add4 (dec_pc_add4),
    .occupancy   (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Memory model: a request counts cycles from its first cycle; ack is
  // raised in cycle mem_lat (0-based) unless held off by mem_en.
  always @(posedge clk) begin
    #1;
    if (imem_req && (!req_prev || imem_ack)) cnt = 0;
    else if (imem_req) cnt = cnt + 1;
    else cnt = 0;
    req_prev = imem_req;
    imem_ack = imem_req && mem_en && (cnt >= mem_lat);
  end

  // Scoreboard monitor: completed fetches and decode transfers.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (imem_req && imem_ack) begin
        n_checks++;
        assert (exp_fetch.size() != 0) else begin
          n_fail++;
          $error("FAIL fetch_extra: observed fetch %h expected none", imem_addr);
        end
        if (exp_fetch.size() != 0) begin
          e = exp_fetch.pop_front();
          chk("fetch_addr", imem_addr, e);
        end
      end
      if (dec_valid && dec_ready && !redirect) begin
        n_checks++;
        assert (exp_pc.size() != 0) else begin
          n_fail++;
          $error("FAIL deliver_extra: observed dec_pc %h expected none", dec_pc);
        end
        if (exp_pc.size() != 0) begin
          e = exp_pc.pop_front();
          chk("dec_pc", dec_pc, e);
          chk("dec_inst", dec_inst, inst_of(e));
          chk("dec_pc_add4", dec_pc_add4, e + 32'd4);
        end
      end
    end
  end

  task automatic wait_issue(input logic [31:0] a, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr === a) found = 1'b1;
      else tick(1);
    end
    n_checks++;
    assert (found) else begin
      n_fail++;
      $error("FAIL %s: observed imem_addr %h expected issue of %h", tag, imem_addr, a);
    end
  endtask

  task automatic wait_occ(input logic [2:0] v, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (occupancy === v) found = 1'b1;
      else tick(1);
    end
    n_checks++;
    assert (found) else begin
      n_fail++;
      $error("FAIL %s: observed occupancy %0d expected %0d", tag, occupancy, v);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (exp_pc.size() == 0 && exp_fetch.size() == 0) done = 1'b1;
      else tick(1);
    end
    n_checks++;
    assert (done) else begin
      n_fail++;
      $error("FAIL %s: observed %0d deliveries and %0d fetches pending expected 0",
             tag, exp_pc.size(), exp_fetch.size());
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    halt      = 1'b0;
    redirect  = 1'b0;
    dec_ready = 1'b0;
    mem_en    = 1'b1;
    mem_lat   = 1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    bit got_ack;
    reset       = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    imem_ack    = 1'b0;
    tick(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_inst", dec_inst, 32'h0);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_pc_add4", dec_pc_add4, 32'h0);

    // Sequential streaming with a consumer always ready
    reset     = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_fetch.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    wait_issue(32'h8, "t1_issue8");
    halt = 1'b1;
    wait_drain("t1_drain");
    tick(2);
    chk("t1_req_idle", 32'(imem_req), 32'd0);
    chk("t1_occ", 32'(occupancy), 32'd0);

    // Fill to DEPTH with the consumer stalled, then free one slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_fetch.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    wait_occ(3'd4, "t2_fill");
    tick(2);
    chk("t2_occ_full", 32'(occupancy), 32'd4);
    chk("t2_req_full", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(dec_valid), 32'd1);
    chk("t2_head_pc", dec_pc, 32'h0);
    exp_fetch.push_back(32'h10);
    exp_pc.push_back(32'h10);
    dec_ready = 1'b1;
    tick(1);
    dec_ready = 1'b0;
    chk("t2_req_refill", 32'(imem_req), 32'd1);
    chk("t2_addr_refill", imem_addr, 32'h10);
    chk("t2_occ_after_deq", 32'(occupancy), 32'd3);
    wait_occ(3'd4, "t2_refill");
    chk("t2_req_stop", 32'(imem_req), 32'd0);
    halt      = 1'b1;
    dec_ready = 1'b1;
    wait_drain("t2_drain");

    // Redirect while a fetch is outstanding; stale word must be dropped
    do_reset();
    dec_ready = 1'b1;
    exp_fetch.push_back(32'h0);
    exp_fetch.push_back(32'h4);
    exp_fetch.push_back(32'h8);
    exp_fetch.push_back(32'h100);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h100);
    wait_issue(32'h8, "t3_issue8");
    mem_en = 1'b0;
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick(1);
    redirect = 1'b0;
    chk("t3_drain_req", 32'(imem_req), 32'd1);
    chk("t3_drain_addr", imem_addr, 32'h8);
    chk("t3_drain_occ", 32'(occupancy), 32'd0);
    tick(1);
    mem_en = 1'b1;
    wait_issue(32'h100, "t3_issue100");
    chk("t3_occ_after_stale", 32'(occupancy), 32'd0);
    halt = 1'b1;
    wait_drain("t3_drain");

    // Redirect on the same edge as an ack; target at the top of memory
    do_reset();
    dec_ready = 1'b1;
    exp_fetch.push_back(32'h0);
    got_ack = 1'b0;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      if (imem_ack) got_ack = 1'b1;
      else tick(1);
    end
    chk("t4_ack_seen", 32'(got_ack), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick(1);
    redirect = 1'b0;
    chk("t4_occ", 32'(occupancy), 32'd0);
    chk("t4_valid", 32'(dec_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'hFFFF_FFFC);
    exp_fetch.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'hFFFF_FFFC);
    halt = 1'b1;
    wait_drain("t4_drain");

    // Halt with two entries queued and one in flight
    do_reset();
    exp_fetch.push_back(32'h0);
    exp_fetch.push_back(32'h4);
    exp_fetch.push_back(32'h8);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h8);
    wait_occ(3'd2, "t5_two");
    chk("t5_req_inflight", 32'(imem_req), 32'd1);
    chk("t5_addr_inflight", imem_addr, 32'h8);
    halt      = 1'b1;
    dec_ready = 1'b1;
    wait_drain("t5_drain");
    tick(3);
    chk("t5_req_halted", 32'(imem_req), 32'd0);
    chk("t5_occ_halted", 32'(occupancy), 32'd0);
    exp_fetch.push_back(32'hC);
    exp_pc.push_back(32'hC);
    halt = 1'b0;
    tick(1);
    chk("t5_resume_req", 32'(imem_req), 32'd1);
    chk("t5_resume_addr", imem_addr, 32'hC);
    halt = 1'b1;
    wait_drain("t5_drain2");

    // Asynchronous reset in WAIT_ACK with three entries queued
    do_reset();
    exp_fetch.push_back(32'h0);
    exp_fetch.push_back(32'h4);
    exp_fetch.push_back(32'h8);
    wait_occ(3'd3, "t6_three");
    chk("t6_req_pre", 32'(imem_req), 32'd1);
    chk("t6_addr_pre", imem_addr, 32'hC);
    reset = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_occ", 32'(occupancy), 32'd0);
    chk("t6_valid", 32'(dec_valid), 32'd0);
    chk("t6_inst", dec_inst, 32'h0);
    chk("t6_pc", dec_pc, 32'h0);
    chk("t6_pc_add4", dec_pc_add4, 32'h0);
    tick(1);
    reset = 1'b0;
    exp_fetch.push_back(32'h0);
    exp_pc.push_back(32'h0);
    dec_ready = 1'b1;
    wait_issue(32'h0, "t6_first_fetch");
    halt = 1'b1;
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
